// File: rtl/multi_state_sequencer.sv
// Multi-state sequencer: steps through NUM_STATES states, each held for dwell[k]+1 tick enables.
// Optional macro SEQ_DEADTIME_EN blanks state_onehot for DEADTIME clks after every advance.
module multi_state_sequencer #(
  parameter int NUM_STATES = 4,
  parameter int DWELL_W    = 8,
  parameter int DEADTIME   = 2,
  localparam int STATE_W   = $clog2(NUM_STATES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          run,
  input  logic                          mode,
  input  logic [NUM_STATES*DWELL_W-1:0] dwell,
  output logic [STATE_W-1:0]            state,
  output logic [NUM_STATES-1:0]         state_onehot,
  output logic                          busy,
  output logic                          cycle_done
);

  localparam logic [STATE_W-1:0] LAST_STATE = STATE_W'(NUM_STATES - 1);

  typedef enum logic {S_IDLE, S_ACTIVE} fsm_e;

  fsm_e               fsm_q, fsm_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               run_d_q, run_d_d;
  logic               cycle_done_q, cycle_done_d;
  logic [DWELL_W-1:0] dwell_arr [NUM_STATES];
  logic [DWELL_W-1:0] cur_dwell;
  logic               onehot_en;

  for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_unpack
    assign dwell_arr[gi] = dwell[gi*DWELL_W +: DWELL_W];
  end

  // Live dwell lookup: a field change takes effect at the next compare.
  always_comb begin
    cur_dwell = '0;
    for (int k = 0; k < NUM_STATES; k++) begin
      if (state_q == STATE_W'(k)) cur_dwell = dwell_arr[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q        <= S_IDLE;
      state_q      <= '0;
      cnt_q        <= '0;
      run_d_q      <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_d_q      <= run_d_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  always_comb begin
    fsm_d        = fsm_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    run_d_d      = run;
    cycle_done_d = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (run && !run_d_q) begin
          fsm_d   = S_ACTIVE;
          state_d = '0;
          cnt_d   = '0;
        end
      end
      S_ACTIVE: begin
        if (tick) begin
          if (cnt_q == cur_dwell) begin
            cnt_d = '0;
            if (state_q == LAST_STATE) begin
              // Wrap: mode and run are only consulted here.
              cycle_done_d = 1'b1;
              state_d      = '0;
              if (mode || !run) fsm_d = S_IDLE;
            end else begin
              state_d = state_q + STATE_W'(1);
            end
          end else begin
            cnt_d = cnt_q + DWELL_W'(1);
          end
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

`ifdef SEQ_DEADTIME_EN
  localparam int DT_W = (DEADTIME < 1) ? 1 : $clog2(DEADTIME + 1);

  logic [DT_W-1:0] dt_q, dt_d;
  logic            advance;

  // Any state change that keeps the sequencer busy (including a continuous wrap) restarts deadtime.
  assign advance = (fsm_q == S_ACTIVE) && (fsm_d == S_ACTIVE) && (state_d != state_q);

  always_comb begin
    dt_d = dt_q;
    if (fsm_d == S_IDLE)   dt_d = '0;
    else if (advance)      dt_d = DT_W'(DEADTIME);
    else if (dt_q != '0)   dt_d = dt_q - DT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) dt_q <= '0;
    else       dt_q <= dt_d;
  end

  assign onehot_en = (dt_q == '0);
`else
  assign onehot_en = 1'b1;
`endif

  always_comb begin
    busy         = (fsm_q == S_ACTIVE);
    state        = state_q;
    cycle_done   = cycle_done_q;
    state_onehot = '0;
    for (int k = 0; k < NUM_STATES; k++) begin
      state_onehot[k] = busy && onehot_en && (state_q == STATE_W'(k));
    end
  end

endmodule

// File: tb/tb_multi_state_sequencer.sv
// Scoreboard bench for multi_state_sequencer (4-state instance plus a 3-state instance).
// Expected outputs are pushed as stimulus is driven and popped one clk later.
module tb_multi_state_sequencer;

`ifdef SEQ_DEADTIME_EN
  localparam int DT = 2;
`else
  localparam int DT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, tick, run, mode;
  logic [31:0] dwell;
  logic [1:0]  state;
  logic [3:0]  state_onehot;
  logic        busy, cycle_done;

  logic        run3, mode3;
  logic [23:0] dwell3;
  logic [1:0]  state3;
  logic [2:0]  onehot3;
  logic        busy3, cycle_done3;

  always #5 clk = ~clk;

  multi_state_sequencer #(.NUM_STATES(4), .DWELL_W(8), .DEADTIME(2)) u_dut (
    .clk(clk), .reset(reset), .tick(tick), .run(run), .mode(mode), .dwell(dwell),
    .state(state), .state_onehot(state_onehot), .busy(busy), .cycle_done(cycle_done)
  );

  multi_state_sequencer #(.NUM_STATES(3), .DWELL_W(8), .DEADTIME(2)) u_dut3 (
    .clk(clk), .reset(reset), .tick(tick), .run(run3), .mode(mode3), .dwell(dwell3),
    .state(state3), .state_onehot(onehot3), .busy(busy3), .cycle_done(cycle_done3)
  );

  typedef struct {
    logic       b;
    logic       cd;
    logic [1:0] s;
    logic [3:0] oh;
  } exp_t;

  exp_t sb[$];
  exp_t sb3[$];
  int   checks = 0;
  int   failures = 0;
  int   since_adv = 100;

  // kind: 0 = no state change, 1 = advance (deadtime restarts), 2 = start/idle/reset (no blanking)
  task automatic push_exp(input logic b, input logic cd, input logic [1:0] s, input int kind);
    exp_t e;
    if (kind == 1)      since_adv = 0;
    else if (kind == 2) since_adv = 100;
    else                since_adv++;
    e.b  = b;
    e.cd = cd;
    e.s  = s;
    e.oh = (b && since_adv >= DT) ? (4'b0001 << s) : 4'b0000;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; run = 1'b0; tick = 1'b0; mode = 1'b0; dwell = '0;
    run3 = 1'b0; mode3 = 1'b0; dwell3 = '0;
    for (int i = 0; i < 2; i++) begin
      push_exp(1'b0, 1'b0, 2'd0, 2);
      cyc();
      e = sb.pop_front();
      checks++;
      if ({busy, cycle_done, state, state_onehot} !== {e.b, e.cd, e.s, e.oh}) begin
        failures++;
        $display("FAIL reset[%0d]: got b=%b cd=%b st=%0d oh=%b, expected b=%b cd=%b st=%0d oh=%b",
                 i, busy, cycle_done, state, state_onehot, e.b, e.cd, e.s, e.oh);
      end else $display("ok reset[%0d] b=%b st=%0d oh=%b", i, busy, state, state_onehot);
    end
    reset = 1'b0;
  endtask

  // All dwell 0, tick high: one state per clk; run dropped in state 1 stops gracefully at the wrap.
  task automatic test_continuous_and_stop();
    exp_t e;
    dwell = '0; mode = 1'b0; tick = 1'b1; run = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      if (k == 10) run = 1'b0;
      if (k == 0)       push_exp(1'b1, 1'b0, 2'd0, 2);
      else if (k < 12)  push_exp(1'b1, (k % 4) == 0, 2'(k % 4), 1);
      else if (k == 12) push_exp(1'b0, 1'b1, 2'd0, 2);
      else              push_exp(1'b0, 1'b0, 2'd0, 0);
      cyc();
      e = sb.pop_front();
      checks++;
      if ({busy, cycle_done, state, state_onehot} !== {e.b, e.cd, e.s, e.oh}) begin
        failures++;
        $display("FAIL continuous[%0d]: got b=%b cd=%b st=%0d oh=%b, expected b=%b cd=%b st=%0d oh=%b",
                 k, busy, cycle_done, state, state_onehot, e.b, e.cd, e.s, e.oh);
      end else $display("ok continuous[%0d] b=%b cd=%b st=%0d oh=%b", k, busy, cycle_done, state, state_onehot);
    end
  endtask

  // Per-state dwell {3,0,2,1} (states 3..0), tick every 5 clks, single-pass with run held high.
  task automatic test_single_pass_dwell();
    exp_t e;
    int   holds [4] = '{2, 3, 1, 4};
    int   s = 0;
    int   n = 0;
    logic done = 1'b0;
    dwell = {8'd3, 8'd0, 8'd2, 8'd1};
    mode = 1'b1; tick = 1'b0; run = 1'b1;
    for (int t = -1; t < 58; t++) begin
      tick = (t >= 0) && (t % 5 == 4);
      if (t == 55) run = 1'b0;
      if (t == 56) begin run = 1'b1; tick = 1'b0; end
      if (t == -1 || t == 56) begin
        push_exp(1'b1, 1'b0, 2'd0, 2);
        done = 1'b0; s = 0; n = 0;
      end else if (done) begin
        push_exp(1'b0, 1'b0, 2'd0, 0);
      end else if (tick) begin
        n++;
        if (n == holds[s]) begin
          n = 0;
          if (s == 3) begin
            done = 1'b1;
            push_exp(1'b0, 1'b1, 2'd0, 2);
          end else begin
            s++;
            push_exp(1'b1, 1'b0, 2'(s), 1);
          end
        end else push_exp(1'b1, 1'b0, 2'(s), 0);
      end else push_exp(1'b1, 1'b0, 2'(s), 0);
      cyc();
      e = sb.pop_front();
      checks++;
      if ({busy, cycle_done, state, state_onehot} !== {e.b, e.cd, e.s, e.oh}) begin
        failures++;
        $display("FAIL single_pass[%0d]: got b=%b cd=%b st=%0d oh=%b, expected b=%b cd=%b st=%0d oh=%b",
                 t, busy, cycle_done, state, state_onehot, e.b, e.cd, e.s, e.oh);
      end else $display("ok single_pass[%0d] b=%b cd=%b st=%0d oh=%b", t, busy, cycle_done, state, state_onehot);
    end
  endtask

  // Reset while in state 2 with its dwell counter part-way: everything clears, no cycle_done.
  task automatic test_reset_mid();
    exp_t e;
    logic [1:0] st_tab [9] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
    logic       b_tab  [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int         kind_tab [9] = '{2, 0, 2, 1, 1, 0, 0, 2, 0};
    dwell = {8'd0, 8'd5, 8'd0, 8'd0};
    mode = 1'b0;
    for (int i = 0; i < 9; i++) begin
      reset = (i == 0) || (i == 7);
      run   = (i >= 2) && (i < 7);
      tick  = (i >= 3);
      push_exp(b_tab[i], 1'b0, st_tab[i], kind_tab[i]);
      cyc();
      e = sb.pop_front();
      checks++;
      if ({busy, cycle_done, state, state_onehot} !== {e.b, e.cd, e.s, e.oh}) begin
        failures++;
        $display("FAIL reset_mid[%0d]: got b=%b cd=%b st=%0d oh=%b, expected b=%b cd=%b st=%0d oh=%b",
                 i, busy, cycle_done, state, state_onehot, e.b, e.cd, e.s, e.oh);
      end else $display("ok reset_mid[%0d] b=%b cd=%b st=%0d oh=%b", i, busy, cycle_done, state, state_onehot);
    end
    reset = 1'b0;
  endtask

  // Three-state build: sequence 0,1,2,0,... never reaching index 3.
  task automatic test_three_states();
    exp_t e;
    tick = 1'b1; mode3 = 1'b0; run3 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      e.b  = 1'b1;
      e.cd = (k > 0) && (k % 3 == 0);
      e.s  = 2'(k % 3);
      e.oh = (k == 0 || DT == 0) ? (4'b0001 << e.s) : 4'b0000;
      sb3.push_back(e);
      cyc();
      e = sb3.pop_front();
      checks++;
      if ({busy3, cycle_done3, state3, onehot3} !== {e.b, e.cd, e.s, e.oh[2:0]} || state3 == 2'd3) begin
        failures++;
        $display("FAIL three_states[%0d]: got b=%b cd=%b st=%0d oh=%b, expected b=%b cd=%b st=%0d oh=%b",
                 k, busy3, cycle_done3, state3, onehot3, e.b, e.cd, e.s, e.oh[2:0]);
      end else $display("ok three_states[%0d] b=%b cd=%b st=%0d oh=%b", k, busy3, cycle_done3, state3, onehot3);
    end
    run3 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_continuous_and_stop();
    test_single_pass_dwell();
    test_reset_mid();
    test_three_states();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
